// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP inference sequencer.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W   = 16;

  // A single layer still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_watchdog.sv
// Per-layer RUN-cycle watchdog: expires while the current RUN cycle is the TIMEOUT-th one.
module mlp_watchdog
  import mlp_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of RUN cycles already completed for this layer.
  assign expired = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mlp_sequencer.sv
// Control FSM that runs one MLP inference by clearing, enabling and capturing each layer in turn.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  in_load,
  input  logic [NUM_LAYERS-1:0]                 layer_end,
  output logic [NUM_LAYERS-1:0]                 layer_en,
  output logic [NUM_LAYERS-1:0]                 layer_clr,
  output logic [NUM_LAYERS-1:0]                 stage_load,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic [clog2_min1(NUM_LAYERS)-1:0]     cur_layer,
  output logic                                  timeout_err,
  input  logic                                  err_clr,
  output logic [CNT_W-1:0]                      inference_count
);

  localparam int K_W = clog2_min1(NUM_LAYERS);

  seq_state_t            r_state;
  seq_state_t            w_next_state;
  logic [K_W-1:0]        r_k;
  logic [K_W-1:0]        w_k_next;
  logic [CNT_W-1:0]      r_count;
  logic [NUM_LAYERS-1:0] w_k_onehot;
  logic                  w_k_last;
  logic                  w_end_k;
  logic                  w_wd_clr;
  logic                  w_wd_inc;
  logic                  w_wd_expired;

  assign w_k_onehot = NUM_LAYERS'(1) << r_k;
  assign w_k_last   = (r_k == K_W'(NUM_LAYERS - 1));
  assign w_end_k    = layer_end[r_k];

  mlp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (w_wd_clr),
    .inc     (w_wd_inc),
    .expired (w_wd_expired)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_k_next;
      if (r_state == S_DONE && out_ready) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_k_next     = r_k;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;
    in_ready     = 1'b0;
    layer_en     = '0;
    layer_clr    = '0;
    stage_load   = '0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    timeout_err  = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_k_next     = '0;
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        layer_clr    = w_k_onehot;
        w_wd_clr     = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        layer_en = w_k_onehot;
        // A layer end in the expiry cycle still counts as success.
        if (w_end_k) begin
          w_next_state = S_CAPTURE;
        end else if (w_wd_expired) begin
          w_next_state = S_ERROR;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      S_CAPTURE: begin
        stage_load = w_k_onehot;
        if (w_k_last) begin
          w_next_state = S_DONE;
        end else begin
          w_k_next     = r_k + 1'b1;
          w_next_state = S_CLEAR;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      S_ERROR: begin
        busy        = 1'b0;
        timeout_err = 1'b1;
        if (err_clr) begin
          w_k_next     = '0;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Gated by reset so no load strobe leaks out while the block is held in reset.
  assign in_load         = in_valid & in_ready & reset;
  assign cur_layer       = r_k;
  assign inference_count = r_count;

endmodule
